wshb_arbiter: RTL and testbench

Grant controller for the shared Wishbone SDRAM port. Watches the `cyc` lines of N Wishbone masters (mire generator, VGA reader, and future requesters) and issues a registered one-hot grant that the Wishbone interconnect uses to steer master signals and route `ack`. Arbitration combines round-robin, a display-urgency override and a starvation guard. A watchdog returns `err` on a stalled transfer.

---
 rtl/wshb_arb_pkg.sv | 38 +++
 rtl/wshb_watchdog.sv | 34 +++
 rtl/wshb_arbiter.sv | 121 ++++++++++++
 tb/tb_wshb_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/wshb_arb_pkg.sv
// Shared types and the round-robin helper for the Wishbone SDRAM-port arbiter.
package wshb_arb_pkg;

  // Widest requester set the arbiter is built for; helpers are sized to it.
  localparam int MAX_N  = 8;
  localparam int MAX_IW = 3;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } arb_state_t;

  typedef struct packed {
    logic              found;
    logic [MAX_IW-1:0] idx;
  } pick_t;

  // First requester with req set, scanning from ptr+1 modulo n, wrapping.
  function automatic pick_t rr_pick(input logic [MAX_N-1:0]  req,
                                    input logic [MAX_IW-1:0] ptr,
                                    input int                n);
    pick_t p;
    int    k;
    p = '0;
    for (int i = 1; i <= MAX_N; i++) begin
      if (i <= n && !p.found) begin
        k = (int'(ptr) + i) % n;
        if (req[k]) begin
          p.found = 1'b1;
          p.idx   = MAX_IW'(k);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/wshb_watchdog.sv
// Stall watchdog: counts consecutive stb-without-ack cycles while a grant is
// active and emits a one-cycle pulse when TIMEOUT of them have elapsed.
module wshb_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic bus_stb,
  input  logic bus_ack,
  output logic err_pulse
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt;

  // Stall counter; an ack on the terminal cycle clears instead of firing.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst || !active || !bus_stb || bus_ack) begin
      cnt       <= '0;
      err_pulse <= 1'b0;
    end else if (cnt == CW'(TIMEOUT - 1)) begin
      cnt       <= '0;
      err_pulse <= 1'b1;
    end else begin
      cnt       <= cnt + 1'b1;
      err_pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/wshb_arbiter.sv
// Grant controller for the shared Wishbone SDRAM port: round-robin with a
// display-urgency override and a starvation guard, plus a stall watchdog.
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int N        = 2,
  parameter int URG_IDX  = 1,
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 urgent,
  input  logic                 bus_stb,
  input  logic                 bus_ack,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid,
  output logic [N-1:0]         err
);

  localparam int IW = $clog2(N);
  localparam int WW = $clog2(MAX_WAIT + 1);

  arb_state_t     state, state_next;
  logic           load;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  winner;
  logic [N-1:0]   starved;
  logic [WW-1:0]  wait_cnt [N];
  pick_t          rr;
  logic           wd_err;

  assign rr = rr_pick(MAX_N'(req), MAX_IW'(ptr), N);

  // A requester is starved once it has watched MAX_WAIT grants go elsewhere.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      starved[i] = req[i] && (wait_cnt[i] == WW'(MAX_WAIT));
    end
  end

  // Winner selection: starvation first, then urgency, then round-robin.
  always_comb begin
    winner = '0;
    if (|starved) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (starved[i]) winner = IW'(i);
      end
    end else if (urgent && req[URG_IDX]) begin
      winner = IW'(URG_IDX);
    end else if (rr.found) begin
      winner = IW'(rr.idx);
    end
  end

  // Next-state logic; the owner keeps the bus until it drops its own cyc.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          load       = 1'b1;
          state_next = GRANT;
        end
      end
      GRANT:   if (!req[gnt_idx]) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      ptr     <= IW'(N - 1);
    end else begin
      state <= state_next;
      if (load) begin
        gnt     <= N'(1) << winner;
        gnt_idx <= winner;
        ptr     <= winner;
      end else if (state == GRANT && state_next == RELEASE) begin
        gnt <= '0;
      end
    end
  end

  // Per-requester wait counters, updated only at grant events.
  always_ff @(posedge clk) begin
    // NOTE: this register array is reset explicitly; it is a handful of
    // flops that feed control, not a RAM, so an unknown start is not allowed.
    if (rst) begin
      for (int i = 0; i < N; i++) wait_cnt[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < N; i++) begin
        if (IW'(i) == winner || !req[i]) wait_cnt[i] <= '0;
        else if (wait_cnt[i] != WW'(MAX_WAIT)) wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end

  wshb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .active    (state == GRANT),
    .bus_stb   (bus_stb),
    .bus_ack   (bus_ack),
    .err_pulse (wd_err)
  );

  assign gnt_valid = |gnt;
  assign err       = wd_err ? (N'(1) << gnt_idx) : '0;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed bench for wshb_arbiter with three requesters and a short timeout.
module tb_wshb_arbiter;

  localparam int N       = 3;
  localparam int TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         urgent;
  logic         bus_stb;
  logic         bus_ack;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_idx;
  logic         gnt_valid;
  logic [N-1:0] err;

  int n_vec  = 0;
  int n_miss = 0;

  wshb_arbiter #(.N(N), .URG_IDX(1), .MAX_WAIT(4), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .urgent    (urgent),
    .bus_stb   (bus_stb),
    .bus_ack   (bus_ack),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req     = '0;
    urgent  = 1'b0;
    bus_stb = 1'b0;
    bus_ack = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Owner drops cyc for one cycle then re-raises; expect 2 dead cycles.
  task automatic handover(input int owner, input logic [N-1:0] req_all, input int nxt);
    req = req_all & ~(N'(1) << owner);
    step();
    check("release gnt", int'(gnt), 0);
    req = req_all;
    step();
    check("idle gnt", int'(gnt), 0);
    step();
    check("new gnt", int'(gnt), 1 << nxt);
    check("new gnt_idx", int'(gnt_idx), nxt);
  endtask

  int seq3 [7] = '{1, 1, 1, 1, 0, 2, 1};

  initial begin
    // Reset values and a single grant/release.
    do_reset();
    check("rst gnt", int'(gnt), 0);
    check("rst gnt_idx", int'(gnt_idx), 0);
    check("rst gnt_valid", int'(gnt_valid), 0);
    check("rst err", int'(err), 0);
    req = 3'b001;
    step();
    check("first gnt", int'(gnt), 1);
    check("first gnt_idx", int'(gnt_idx), 0);
    check("first gnt_valid", int'(gnt_valid), 1);
    req = 3'b000;
    step();
    check("drop gnt c1", int'(gnt), 0);
    check("drop valid c1", int'(gnt_valid), 0);
    step();
    check("drop gnt c2", int'(gnt), 0);

    // Round-robin between 0 and 1, eight acks per tenure.
    do_reset();
    req = 3'b011;
    step();
    check("rr gnt0", int'(gnt), 1);
    for (int r = 0; r < 3; r++) begin
      bus_stb = 1'b1;
      bus_ack = 1'b1;
      for (int a = 0; a < 8; a++) step();
      check("rr no err", int'(err), 0);
      bus_stb = 1'b0;
      bus_ack = 1'b0;
      handover(r % 2, 3'b011, (r + 1) % 2);
    end

    // Urgency favours 1 until the starvation guard forces 0, then 2.
    do_reset();
    urgent = 1'b1;
    req    = 3'b111;
    step();
    check("urg gnt", int'(gnt), 2);
    for (int g = 1; g < 7; g++) handover(seq3[g-1], 3'b111, seq3[g]);

    // Pure stall: err on the 16th stalled cycle, grant kept.
    do_reset();
    req = 3'b001;
    step();
    check("wd gnt", int'(gnt), 1);
    bus_stb = 1'b1;
    for (int i = 1; i < TIMEOUT; i++) step();
    check("wd err before", int'(err), 0);
    step();
    check("wd err pulse", int'(err), 1);
    step();
    check("wd err cleared", int'(err), 0);
    check("wd gnt kept", int'(gnt), 1);
    req     = 3'b000;
    bus_stb = 1'b0;
    step();
    check("wd gnt dropped", int'(gnt), 0);

    // Ack on the 16th cycle wins; counter then restarts from zero.
    do_reset();
    req = 3'b001;
    step();
    bus_stb = 1'b1;
    for (int i = 1; i < TIMEOUT; i++) step();
    check("ack15 err", int'(err), 0);
    bus_ack = 1'b1;
    step();
    check("ack16 err", int'(err), 0);
    bus_ack = 1'b0;
    for (int i = 1; i < TIMEOUT; i++) step();
    check("restart err early", int'(err), 0);
    step();
    check("restart err pulse", int'(err), 1);
    bus_stb = 1'b0;
    req     = 3'b000;
    step();
    step();

    // Reset during a stalled grant to requester 1.
    do_reset();
    req = 3'b011;
    step();
    check("prerst gnt0", int'(gnt), 1);
    handover(0, 3'b011, 1);
    bus_stb = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    check("midrst gnt", int'(gnt), 0);
    check("midrst gnt_idx", int'(gnt_idx), 0);
    check("midrst valid", int'(gnt_valid), 0);
    check("midrst err", int'(err), 0);
    rst     = 1'b0;
    bus_stb = 1'b0;
    step();
    check("postrst gnt", int'(gnt), 1);
    check("postrst gnt_idx", int'(gnt_idx), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
